frame_tx: RTL and testbench

// - Transmit-side counterpart of frame_aligner: builds framed byte stream, one byte per clk.
// - Frame = 2-byte header (LSB then MSB) + PAYLOAD_LEN payload bytes, no gaps between bytes.
// - Output feeds the rx_data input of frame_aligner in loopback benches and system top.

---
 rtl/frame_tx.sv | 130 +++++++++++++
 tb/tb_frame_tx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/frame_tx.sv
// frame_tx: builds a framed byte stream (2-byte header LSB/MSB + PAYLOAD_LEN payload), one byte per clk.
// Define FRAME_TX_CORRUPT_EN to enable per-frame MSB-header corruption via corrupt_hdr.
module frame_tx #(
  parameter int         PAYLOAD_LEN = 10,
  parameter logic [7:0] HDR_A_LSB   = 8'hAA,
  parameter logic [7:0] HDR_A_MSB   = 8'hAF,
  parameter logic [7:0] HDR_B_LSB   = 8'h55,
  parameter logic [7:0] HDR_B_MSB   = 8'hBA,
  parameter logic [7:0] FILL_BYTE   = 8'h00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tx_en,
  input  logic        hdr_sel,
  input  logic        pl_valid,
  input  logic [7:0]  pl_data,
  output logic        pl_ready,
  input  logic        corrupt_hdr,
  output logic [7:0]  tx_data,
  output logic [3:0]  tx_byte_position,
  output logic        tx_sof,
  output logic        tx_active,
  output logic        underrun,
  output logic [15:0] frames_sent
);

  typedef enum logic [1:0] {S_IDLE, S_HDR_LSB, S_HDR_MSB, S_PAYLOAD} state_t;

  localparam logic [3:0] LAST_CNT = 4'(PAYLOAD_LEN - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_sel;
  logic [7:0]  r_tx_data;
  logic [3:0]  r_pos;
  logic        r_sof;
  logic        r_active;
  logic        r_underrun;
  logic [15:0] r_frames;

  logic [7:0]  w_hdr_lsb;
  logic [7:0]  w_hdr_msb;
  logic [7:0]  w_msb_flip;

`ifdef FRAME_TX_CORRUPT_EN
  logic        r_corrupt;
  assign w_msb_flip = r_corrupt ? 8'hFF : 8'h00;
`else
  logic        w_unused_corrupt;
  assign w_unused_corrupt = corrupt_hdr;
  assign w_msb_flip       = 8'h00;
`endif

  // hdr_sel is used live for the LSB byte and latched for the rest of the frame
  assign w_hdr_lsb = hdr_sel ? HDR_B_LSB : HDR_A_LSB;
  assign w_hdr_msb = (r_sel ? HDR_B_MSB : HDR_A_MSB) ^ w_msb_flip;
  assign pl_ready  = (r_state == S_PAYLOAD);

  assign tx_data          = r_tx_data;
  assign tx_byte_position = r_pos;
  assign tx_sof           = r_sof;
  assign tx_active        = r_active;
  assign underrun         = r_underrun;
  assign frames_sent      = r_frames;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_sel      <= 1'b0;
      r_tx_data  <= FILL_BYTE;
      r_pos      <= 4'd0;
      r_sof      <= 1'b0;
      r_active   <= 1'b0;
      r_underrun <= 1'b0;
      r_frames   <= 16'd0;
`ifdef FRAME_TX_CORRUPT_EN
      r_corrupt  <= 1'b0;
`endif
    end else begin
      r_sof      <= 1'b0;
      r_underrun <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx_data <= FILL_BYTE;
          r_pos     <= 4'd0;
          r_active  <= 1'b0;
          if (tx_en) r_state <= S_HDR_LSB;
        end
        S_HDR_LSB: begin
          r_sel     <= hdr_sel;
`ifdef FRAME_TX_CORRUPT_EN
          r_corrupt <= corrupt_hdr;
`endif
          r_tx_data <= w_hdr_lsb;
          r_pos     <= 4'd0;
          r_sof     <= 1'b1;
          r_active  <= 1'b1;
          r_state   <= S_HDR_MSB;
        end
        S_HDR_MSB: begin
          r_tx_data <= w_hdr_msb;
          r_pos     <= 4'd1;
          r_active  <= 1'b1;
          r_cnt     <= 4'd0;
          r_state   <= S_PAYLOAD;
        end
        S_PAYLOAD: begin
          r_active <= 1'b1;
          r_pos    <= r_cnt + 4'd2;
          // a missing payload byte is replaced, never skipped, so frame length is fixed
          if (pl_valid) begin
            r_tx_data <= pl_data;
          end else begin
            r_tx_data  <= FILL_BYTE;
            r_underrun <= 1'b1;
          end
          if (r_cnt == LAST_CNT) begin
            r_frames <= r_frames + 16'd1;
            r_state  <= tx_en ? S_HDR_LSB : S_IDLE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_tx.sv
// Directed bench for frame_tx: reset, type A/B frames, back-to-back, underrun, tx_en drop, header corruption.
module tb_frame_tx;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        tx_en;
  logic        hdr_sel;
  logic        pl_valid;
  logic [7:0]  pl_data;
  logic        pl_ready;
  logic        corrupt_hdr;
  logic [7:0]  tx_data;
  logic [3:0]  tx_byte_position;
  logic        tx_sof;
  logic        tx_active;
  logic        underrun;
  logic [15:0] frames_sent;

  frame_tx dut (
    .clk(clk), .reset_n(reset_n), .tx_en(tx_en), .hdr_sel(hdr_sel),
    .pl_valid(pl_valid), .pl_data(pl_data), .pl_ready(pl_ready),
    .corrupt_hdr(corrupt_hdr), .tx_data(tx_data), .tx_byte_position(tx_byte_position),
    .tx_sof(tx_sof), .tx_active(tx_active), .underrun(underrun), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] o_data [0:63];
  logic [3:0] o_pos  [0:63];
  logic       o_sof  [0:63];
  logic       o_act  [0:63];
  logic       o_und  [0:63];

  logic [7:0] src;
  logic       xfer;
  int         pcyc, under_at, drop_frames, drop_pos, corrupt_frame;

  task automatic do_reset();
    reset_n = 1'b0; tx_en = 1'b0; hdr_sel = 1'b0; pl_valid = 1'b1; corrupt_hdr = 1'b0;
    src = 8'd1; pl_data = 8'd1; xfer = 1'b0; pcyc = 0; under_at = -1;
    drop_frames = -1; drop_pos = 0; corrupt_frame = -1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Samples outputs at each negedge and drives the payload source / tx_en schedule.
  task automatic capture(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      o_data[k] = tx_data; o_pos[k] = tx_byte_position; o_sof[k] = tx_sof;
      o_act[k] = tx_active; o_und[k] = underrun;
      if (xfer) src = src + 8'd1;
      pl_data = src;
      if (pl_ready) begin
        pl_valid = (pcyc != under_at);
        pcyc++;
      end else begin
        pl_valid = 1'b1;
      end
      xfer = pl_ready && pl_valid;
      if (drop_frames >= 0 && int'(frames_sent) == drop_frames && tx_active &&
          int'(tx_byte_position) == drop_pos)
        tx_en = 1'b0;
      corrupt_hdr = (int'(frames_sent) == corrupt_frame);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_data got %h want 00", tx_data); end
    checks++; if (tx_byte_position !== 4'd0) begin failures++; $display("FAIL reset_pos got %0d want 0", tx_byte_position); end
    checks++; if (tx_sof !== 1'b0) begin failures++; $display("FAIL reset_sof got %b want 0", tx_sof); end
    checks++; if (tx_active !== 1'b0) begin failures++; $display("FAIL reset_active got %b want 0", tx_active); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun got %b want 0", underrun); end
    checks++; if (frames_sent !== 16'd0) begin failures++; $display("FAIL reset_frames got %0d want 0", frames_sent); end
    checks++; if (pl_ready !== 1'b0) begin failures++; $display("FAIL reset_pl_ready got %b want 0", pl_ready); end
  endtask

  task automatic test_frame_a();
    logic [7:0] e;
    do_reset();
    hdr_sel = 1'b0; drop_frames = 0; drop_pos = 0; tx_en = 1'b1;
    capture(15);
    checks++; if (o_act[0] !== 1'b0 || o_data[0] !== 8'h00) begin failures++; $display("FAIL a_start_latency got act=%b data=%h want act=0 data=00", o_act[0], o_data[0]); end
    for (int j = 0; j < 12; j++) begin
      e = (j == 0) ? 8'hAA : (j == 1) ? 8'hAF : 8'(j - 1);
      checks++; if (o_data[1+j] !== e) begin failures++; $display("FAIL a_data j=%0d got %h want %h", j, o_data[1+j], e); end
      checks++; if (o_pos[1+j] !== 4'(j)) begin failures++; $display("FAIL a_pos j=%0d got %0d want %0d", j, o_pos[1+j], j); end
      checks++; if (o_sof[1+j] !== (j == 0)) begin failures++; $display("FAIL a_sof j=%0d got %b want %b", j, o_sof[1+j], (j == 0)); end
      checks++; if (o_act[1+j] !== 1'b1) begin failures++; $display("FAIL a_active j=%0d got %b want 1", j, o_act[1+j]); end
    end
    for (int k = 13; k < 15; k++) begin
      checks++; if (o_act[k] !== 1'b0 || o_data[k] !== 8'h00) begin failures++; $display("FAIL a_idle k=%0d got act=%b data=%h want act=0 data=00", k, o_act[k], o_data[k]); end
    end
    checks++; if (frames_sent !== 16'd1) begin failures++; $display("FAIL a_frames got %0d want 1", frames_sent); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    do_reset();
    hdr_sel = 1'b1; drop_frames = 2; drop_pos = 0; tx_en = 1'b1;
    capture(39);
    for (int f = 0; f < 3; f++) begin
      for (int j = 0; j < 12; j++) begin
        e = (j == 0) ? 8'h55 : (j == 1) ? 8'hBA : 8'(10 * f + j - 1);
        checks++; if (o_data[1+12*f+j] !== e || o_pos[1+12*f+j] !== 4'(j)) begin
          failures++; $display("FAIL b2b f=%0d j=%0d got data=%h pos=%0d want data=%h pos=%0d",
                               f, j, o_data[1+12*f+j], o_pos[1+12*f+j], e, j);
        end
      end
    end
    checks++; if (o_act[37] !== 1'b0 || o_data[37] !== 8'h00) begin failures++; $display("FAIL b2b_idle got act=%b data=%h want act=0 data=00", o_act[37], o_data[37]); end
    checks++; if (frames_sent !== 16'd3) begin failures++; $display("FAIL b2b_frames got %0d want 3", frames_sent); end
  endtask

  task automatic test_underrun();
    logic [7:0] e;
    do_reset();
    hdr_sel = 1'b0; drop_frames = 0; drop_pos = 0; under_at = 4; tx_en = 1'b1;
    capture(15);
    for (int j = 2; j < 12; j++) begin
      e = (j < 6) ? 8'(j - 1) : (j == 6) ? 8'h00 : 8'(j - 2);
      checks++; if (o_data[1+j] !== e || o_pos[1+j] !== 4'(j)) begin
        failures++; $display("FAIL und_data pos=%0d got data=%h pos=%0d want data=%h", j, o_data[1+j], o_pos[1+j], e);
      end
    end
    for (int k = 0; k < 15; k++) begin
      checks++; if (o_und[k] !== (k == 7)) begin failures++; $display("FAIL und_pulse k=%0d got %b want %b", k, o_und[k], (k == 7)); end
    end
    checks++; if (o_act[12] !== 1'b1 || o_act[13] !== 1'b0) begin failures++; $display("FAIL und_length got act12=%b act13=%b want 1 0", o_act[12], o_act[13]); end
    checks++; if (frames_sent !== 16'd1) begin failures++; $display("FAIL und_frames got %0d want 1", frames_sent); end
  endtask

  task automatic test_en_drop();
    do_reset();
    hdr_sel = 1'b0; drop_frames = 0; drop_pos = 4; tx_en = 1'b1;
    capture(16);
    checks++; if (o_pos[12] !== 4'd11 || o_data[12] !== 8'h0A || o_act[12] !== 1'b1) begin
      failures++; $display("FAIL drop_last got pos=%0d data=%h act=%b want 11 0a 1", o_pos[12], o_data[12], o_act[12]);
    end
    for (int k = 13; k < 16; k++) begin
      checks++; if (o_act[k] !== 1'b0 || o_data[k] !== 8'h00 || o_sof[k] !== 1'b0) begin
        failures++; $display("FAIL drop_idle k=%0d got act=%b data=%h sof=%b want 0 00 0", k, o_act[k], o_data[k], o_sof[k]);
      end
    end
    checks++; if (frames_sent !== 16'd1) begin failures++; $display("FAIL drop_frames got %0d want 1", frames_sent); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    hdr_sel = 1'b0; tx_en = 1'b1;
    capture(20);
    checks++; if (frames_sent !== 16'd1 || tx_active !== 1'b1) begin
      failures++; $display("FAIL midrst_pre got frames=%0d act=%b want 1 1", frames_sent, tx_active);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL midrst_data got %h want 00", tx_data); end
    checks++; if (tx_active !== 1'b0) begin failures++; $display("FAIL midrst_active got %b want 0", tx_active); end
    checks++; if (frames_sent !== 16'd0) begin failures++; $display("FAIL midrst_frames got %0d want 0", frames_sent); end
    checks++; if (tx_byte_position !== 4'd0) begin failures++; $display("FAIL midrst_pos got %0d want 0", tx_byte_position); end
    @(negedge clk);
    tx_en = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_corrupt();
    logic [7:0] e_msb;
`ifdef FRAME_TX_CORRUPT_EN
    e_msb = 8'h50;
`else
    e_msb = 8'hAF;
`endif
    do_reset();
    hdr_sel = 1'b0; drop_frames = 1; drop_pos = 0; corrupt_frame = 1; tx_en = 1'b1;
    capture(27);
    checks++; if (o_data[2] !== 8'hAF) begin failures++; $display("FAIL cor_f0_msb got %h want af", o_data[2]); end
    checks++; if (o_data[13] !== 8'hAA || o_sof[13] !== 1'b1) begin failures++; $display("FAIL cor_f1_lsb got %h sof=%b want aa 1", o_data[13], o_sof[13]); end
    checks++; if (o_data[14] !== e_msb || o_pos[14] !== 4'd1) begin failures++; $display("FAIL cor_f1_msb got %h pos=%0d want %h 1", o_data[14], o_pos[14], e_msb); end
    checks++; if (o_data[15] !== 8'h0B) begin failures++; $display("FAIL cor_f1_pl got %h want 0b", o_data[15]); end
    checks++; if (frames_sent !== 16'd2) begin failures++; $display("FAIL cor_frames got %0d want 2", frames_sent); end
  endtask

  initial begin
    test_reset();
    test_frame_a();
    test_back_to_back();
    test_underrun();
    test_en_drop();
    test_reset_mid_frame();
    test_corrupt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
